// File: rtl/clk_meas_pkg.sv
// Shared definitions for the divided-clock ratio meter.
//   meas_state_t : measurement FSM encoding (IDLE, PARTIAL, TRACK, LOCKED)
//   DEF_W        : default width of the ratio and phase counters
//   DEF_LOCK_CNT : default number of identical periods needed for lock
//   DEF_TIMEOUT  : default ref-cycle count without an edge before timeout
package clk_meas_pkg;

   localparam int DEF_W        = 8;
   localparam int DEF_LOCK_CNT = 4;
   localparam int DEF_TIMEOUT  = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PARTIAL = 2'd1,
      TRACK   = 2'd2,
      LOCKED  = 2'd3
   } meas_state_t;

endpackage

// File: rtl/clk_edge_det.sv
// Two-flop sampler and edge detector for the clock under test.
// The clock under test is launched from a flop on i_ref_clk, so no
// synchronizer is needed; s1/s2 only provide the delayed copy for edges.
//   i_ref_clk : reference clock (posedge)
//   i_clr     : synchronous clear of both sample flops
//   i_div_clk : clock under test
//   o_rise    : combinational, s1 & ~s2
//   o_fall    : combinational, ~s1 & s2
module clk_edge_det (
   input  logic i_ref_clk,
   input  logic i_clr,
   input  logic i_div_clk,
   output logic o_rise,
   output logic o_fall
);

   logic s1;
   logic s2;

   always_ff @(posedge i_ref_clk) begin
      if (i_clr) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= i_div_clk;
         s2 <= s1;
      end
   end

   assign o_rise = s1 & ~s2;
   assign o_fall = ~s1 & s2;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period and high/low phase lengths of a divided clock in
// reference-clock cycles, and reports lock, period errors and timeout.
//   i_ref_clk   : reference clock, all logic on posedge
//   i_rst_n     : synchronous reset, active low (wins over everything)
//   i_clk_en    : measurement enable; 0 clears all state synchronously
//   i_div_clk   : clock under test
//   o_div_ratio : last measured period (high+low), saturated at 2^W-1
//   o_high_cnt  : last measured high-phase length
//   o_low_cnt   : last measured low-phase length
//   o_valid     : 1-cycle pulse when a new period is captured
//   o_locked    : LOCK_CNT consecutive identical periods seen
//   o_err       : 1-cycle pulse on period change while locked, or overflow
//   o_timeout   : no edge for TIMEOUT cycles; clears on the next edge
module clk_ratio_meter
   import clk_meas_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic         i_ref_clk,
   input  logic         i_rst_n,
   input  logic         i_clk_en,
   input  logic         i_div_clk,
   output logic [W-1:0] o_div_ratio,
   output logic [W-1:0] o_high_cnt,
   output logic [W-1:0] o_low_cnt,
   output logic         o_valid,
   output logic         o_locked,
   output logic         o_err,
   output logic         o_timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0] LOCK_M    = MW'(LOCK_CNT);
   localparam logic [W-1:0]  CNT_MAX   = '1;
   localparam logic [W-1:0]  TIMEOUT_V = W'(TIMEOUT);

   logic clr;
   logic rise;
   logic fall;

   meas_state_t   state_q, state_d;
   logic [MW-1:0] match_q, match_d;
   logic [W-1:0]  cnt;
   logic [W-1:0]  high_len;
   logic [W-1:0]  prev_period;
   logic [W:0]    period_full;
   logic          ovf;
   logic [W-1:0]  period_sat;
   logic          upd;
   logic          valid_d;
   logic          err_d;
   logic          locked_d;
   logic          timeout_d;

   assign clr = !i_rst_n || !i_clk_en;

   clk_edge_det u_edge (
      .i_ref_clk (i_ref_clk),
      .i_clr     (clr),
      .i_div_clk (i_div_clk),
      .o_rise    (rise),
      .o_fall    (fall)
   );

   // On a rise, cnt holds the low-phase length just finished, so the full
   // period is the captured high phase plus the live counter.
   assign period_full = {1'b0, high_len} + {1'b0, cnt};
   assign ovf         = period_full[W];
   assign period_sat  = ovf ? CNT_MAX : period_full[W-1:0];

   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      locked_d  = o_locked;
      timeout_d = o_timeout;
      upd       = 1'b0;

      if (rise || fall) begin
         timeout_d = 1'b0;
      end

      if (rise) begin
         case (state_q)
            IDLE: state_d = PARTIAL;
            // The high phase seen so far may be truncated; wait one more rise.
            PARTIAL: begin
               state_d = TRACK;
               match_d = '0;
            end
            default: begin
               upd     = 1'b1;
               valid_d = 1'b1;
               if (ovf) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = '0;
                  state_d  = TRACK;
               end else if (state_q == LOCKED) begin
                  if (period_sat != prev_period) begin
                     err_d    = 1'b1;
                     locked_d = 1'b0;
                     match_d  = MW'(1);
                     state_d  = TRACK;
                  end
               end else begin
                  match_d = (period_sat == prev_period) ? match_q + MW'(1) : MW'(1);
                  if (match_d == LOCK_M) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end
            end
         endcase
      end else if (!fall && cnt == TIMEOUT_V) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         match_d   = '0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge i_ref_clk) begin
      if (clr) begin
         state_q     <= IDLE;
         match_q     <= '0;
         cnt         <= '0;
         high_len    <= '0;
         prev_period <= '0;
         o_div_ratio <= '0;
         o_high_cnt  <= '0;
         o_low_cnt   <= '0;
         o_valid     <= 1'b0;
         o_locked    <= 1'b0;
         o_err       <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         o_valid   <= valid_d;
         o_locked  <= locked_d;
         o_err     <= err_d;
         o_timeout <= timeout_d;

         if (rise || fall) begin
            cnt <= W'(1);
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + W'(1);
         end

         if (fall) begin
            high_len <= cnt;
         end

         if (upd) begin
            prev_period <= period_sat;
            o_div_ratio <= period_sat;
            o_high_cnt  <= high_len;
            o_low_cnt   <= cnt;
         end
      end
   end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: a behavioural programmable divider
// drives i_div_clk, outputs are sampled on the falling edge of i_ref_clk.
module tb_clk_ratio_meter;

   localparam int W = 8;

   logic         i_ref_clk = 1'b0;
   logic         i_rst_n   = 1'b0;
   logic         i_clk_en  = 1'b0;
   logic         i_div_clk = 1'b0;
   logic [W-1:0] o_div_ratio;
   logic [W-1:0] o_high_cnt;
   logic [W-1:0] o_low_cnt;
   logic         o_valid;
   logic         o_locked;
   logic         o_err;
   logic         o_timeout;

   int vec_cnt = 0;
   int err_cnt = 0;

   // divider model state
   int div_n       = 2;
   int cur_n       = 2;
   int cnt_d       = 1;
   bit div_hold    = 1'b0;
   bit div_restart = 1'b0;

   clk_ratio_meter #(.W(W), .LOCK_CNT(4), .TIMEOUT(255)) dut (
      .i_ref_clk   (i_ref_clk),
      .i_rst_n     (i_rst_n),
      .i_clk_en    (i_clk_en),
      .i_div_clk   (i_div_clk),
      .o_div_ratio (o_div_ratio),
      .o_high_cnt  (o_high_cnt),
      .o_low_cnt   (o_low_cnt),
      .o_valid     (o_valid),
      .o_locked    (o_locked),
      .o_err       (o_err),
      .o_timeout   (o_timeout)
   );

   initial forever #30 i_ref_clk = ~i_ref_clk;

   // Divider: high for n/2 cycles, low for the rest; a new ratio takes
   // effect only at a period boundary so every period is pure.
   initial begin
      forever begin
         @(negedge i_ref_clk);
         if (div_hold || div_restart) begin
            i_div_clk = 1'b0;
            cur_n     = div_n;
            cnt_d     = cur_n - 1;
         end else begin
            if (cnt_d >= cur_n - 1) begin
               cnt_d = 0;
               cur_n = div_n;
            end else begin
               cnt_d++;
            end
            i_div_clk = (cnt_d < cur_n / 2);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(input int budget, output int cycles, output bit got);
      got    = 1'b0;
      cycles = 0;
      while (!got && cycles < budget) begin
         @(negedge i_ref_clk);
         cycles++;
         if (o_valid) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      i_rst_n  = 1'b0;
      i_clk_en = 1'b1;
      repeat (3) @(negedge i_ref_clk);
      vec_cnt++; if (o_div_ratio !== '0) begin err_cnt++; $display("FAIL reset_ratio: got %0d want 0", o_div_ratio); end
      vec_cnt++; if (o_high_cnt !== '0) begin err_cnt++; $display("FAIL reset_high: got %0d want 0", o_high_cnt); end
      vec_cnt++; if (o_low_cnt !== '0) begin err_cnt++; $display("FAIL reset_low: got %0d want 0", o_low_cnt); end
      vec_cnt++; if ({o_valid, o_locked, o_err, o_timeout} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags: got %b want 0000", {o_valid, o_locked, o_err, o_timeout}); end
      i_rst_n = 1'b1;
   endtask

   // Soft-clear, restart the divider at ratio n, then check six periods.
   task automatic test_ratio(input int n, input int h, input int l);
      int cyc;
      bit got;
      @(negedge i_ref_clk);
      i_clk_en    = 1'b0;
      div_n       = n;
      div_restart = 1'b1;
      repeat (2) @(negedge i_ref_clk);
      vec_cnt++; if (o_div_ratio !== '0 || o_locked !== 1'b0) begin err_cnt++; $display("FAIL clear_%0d: got ratio %0d locked %b want 0 0", n, o_div_ratio, o_locked); end
      div_restart = 1'b0;
      i_clk_en    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         wait_valid(4 * n + 10, cyc, got);
         vec_cnt++;
         if (!got) begin
            err_cnt++; $display("FAIL valid_%0d_%0d: got no o_valid in %0d cycles want pulse", n, k, cyc);
         end else begin
            vec_cnt++; if (int'(o_div_ratio) !== n) begin err_cnt++; $display("FAIL ratio_%0d_%0d: got %0d want %0d", n, k, o_div_ratio, n); end
            vec_cnt++; if (int'(o_high_cnt) !== h) begin err_cnt++; $display("FAIL high_%0d_%0d: got %0d want %0d", n, k, o_high_cnt, h); end
            vec_cnt++; if (int'(o_low_cnt) !== l) begin err_cnt++; $display("FAIL low_%0d_%0d: got %0d want %0d", n, k, o_low_cnt, l); end
            vec_cnt++; if (o_err !== 1'b0) begin err_cnt++; $display("FAIL err_%0d_%0d: got %b want 0", n, k, o_err); end
            vec_cnt++; if (o_locked !== (k >= 4)) begin err_cnt++; $display("FAIL lock_%0d_%0d: got %b want %b", n, k, o_locked, (k >= 4)); end
            if (k > 1) begin
               vec_cnt++; if (cyc !== n) begin err_cnt++; $display("FAIL spacing_%0d_%0d: got %0d want %0d", n, k, cyc, n); end
            end
         end
      end
   endtask

   task automatic test_ratio_change();
      int cyc;
      bit got;
      bit got6;
      test_ratio(4, 2, 2);
      div_n = 6;
      got6  = 1'b0;
      for (int i = 0; i < 3 && !got6; i++) begin
         wait_valid(20, cyc, got);
         if (got && int'(o_div_ratio) != 4) got6 = 1'b1;
      end
      vec_cnt++;
      if (!got6) begin
         err_cnt++; $display("FAIL change_seen: got ratio %0d want 6", o_div_ratio);
      end else begin
         vec_cnt++; if (o_div_ratio !== 8'd6 || o_high_cnt !== 8'd3 || o_low_cnt !== 8'd3) begin err_cnt++; $display("FAIL change_vals: got %0d/%0d/%0d want 6/3/3", o_div_ratio, o_high_cnt, o_low_cnt); end
         vec_cnt++; if (o_err !== 1'b1) begin err_cnt++; $display("FAIL change_err: got %b want 1", o_err); end
         vec_cnt++; if (o_locked !== 1'b0) begin err_cnt++; $display("FAIL change_unlock: got %b want 0", o_locked); end
      end
      for (int k = 1; k <= 3; k++) begin
         wait_valid(20, cyc, got);
         vec_cnt++;
         if (!got) begin
            err_cnt++; $display("FAIL relock_valid_%0d: got no o_valid want pulse", k);
         end else begin
            vec_cnt++; if (o_div_ratio !== 8'd6 || o_err !== 1'b0) begin err_cnt++; $display("FAIL relock_ratio_%0d: got %0d err %b want 6 err 0", k, o_div_ratio, o_err); end
            vec_cnt++; if (o_locked !== (k == 3)) begin err_cnt++; $display("FAIL relock_lock_%0d: got %b want %b", k, o_locked, (k == 3)); end
         end
      end
   endtask

   task automatic test_timeout();
      int cyc;
      bit got;
      div_hold = 1'b1;
      cyc = 0;
      while (!o_timeout && cyc < 400) begin
         @(negedge i_ref_clk);
         cyc++;
      end
      vec_cnt++; if (o_timeout !== 1'b1) begin err_cnt++; $display("FAIL timeout_set: got %b want 1", o_timeout); end
      vec_cnt++; if (cyc < 250 || cyc > 262) begin err_cnt++; $display("FAIL timeout_delay: got %0d cycles want 250..262", cyc); end
      vec_cnt++; if (o_locked !== 1'b0) begin err_cnt++; $display("FAIL timeout_unlock: got %b want 0", o_locked); end
      vec_cnt++; if (o_div_ratio !== 8'd6 || o_high_cnt !== 8'd3 || o_low_cnt !== 8'd3) begin err_cnt++; $display("FAIL timeout_hold: got %0d/%0d/%0d want 6/3/3", o_div_ratio, o_high_cnt, o_low_cnt); end
      div_hold = 1'b0;
      cyc = 0;
      while (o_timeout && cyc < 20) begin
         @(negedge i_ref_clk);
         cyc++;
      end
      vec_cnt++; if (o_timeout !== 1'b0) begin err_cnt++; $display("FAIL timeout_clear: got %b want 0", o_timeout); end
      for (int k = 1; k <= 4; k++) begin
         wait_valid(40, cyc, got);
         vec_cnt++;
         if (!got || o_div_ratio !== 8'd6 || o_locked !== (k == 4)) begin
            err_cnt++; $display("FAIL resume_%0d: got valid %b ratio %0d locked %b want 1 6 %b", k, got, o_div_ratio, o_locked, (k == 4));
         end
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit got;
      @(negedge i_ref_clk);
      i_rst_n = 1'b0;
      @(negedge i_ref_clk);
      vec_cnt++; if ({o_div_ratio, o_high_cnt, o_low_cnt} !== '0) begin err_cnt++; $display("FAIL midrst_vals: got %0d/%0d/%0d want 0/0/0", o_div_ratio, o_high_cnt, o_low_cnt); end
      vec_cnt++; if ({o_valid, o_locked, o_err, o_timeout} !== 4'b0) begin err_cnt++; $display("FAIL midrst_flags: got %b want 0000", {o_valid, o_locked, o_err, o_timeout}); end
      i_rst_n = 1'b1;
      wait_valid(40, cyc, got);
      vec_cnt++; if (!got || cyc <= 6) begin err_cnt++; $display("FAIL midrst_first: got valid %b after %0d cycles want 1 after >6", got, cyc); end
      vec_cnt++; if (o_div_ratio !== 8'd6) begin err_cnt++; $display("FAIL midrst_ratio: got %0d want 6", o_div_ratio); end
   endtask

   task automatic test_enable();
      int cyc;
      bit got;
      bit seen;
      for (int k = 1; k <= 4; k++) wait_valid(20, cyc, got);
      vec_cnt++; if (o_locked !== 1'b1) begin err_cnt++; $display("FAIL en_prelock: got %b want 1", o_locked); end
      repeat (2) @(negedge i_ref_clk);
      i_clk_en = 1'b0;
      @(negedge i_ref_clk);
      vec_cnt++; if (o_div_ratio !== '0 || o_high_cnt !== '0 || o_locked !== 1'b0) begin err_cnt++; $display("FAIL en_clear: got %0d/%0d locked %b want 0/0 0", o_div_ratio, o_high_cnt, o_locked); end
      seen = 1'b0;
      repeat (10) begin
         @(negedge i_ref_clk);
         if (o_valid) seen = 1'b1;
      end
      vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL en_quiet: got o_valid %b want 0", seen); end
      i_clk_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wait_valid(40, cyc, got);
         vec_cnt++;
         if (!got || o_div_ratio !== 8'd6 || o_locked !== (k == 4)) begin
            err_cnt++; $display("FAIL en_relock_%0d: got valid %b ratio %0d locked %b want 1 6 %b", k, got, o_div_ratio, o_locked, (k == 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_ratio(2, 1, 1);
      test_ratio(3, 1, 2);
      test_ratio(5, 2, 3);
      test_ratio_change();
      test_timeout();
      test_reset_mid();
      test_enable();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
